// File: rtl/ahb_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_cmd_sequencer_pkg
// Purpose  : Shared types, state encodings and defaults for the AHB command
//            sequencer and its command queue.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_cmd_sequencer_pkg;

    localparam int c_DEFAULT_FIFO_DEPTH = 4;
    localparam int c_DEFAULT_TIMEOUT    = 255;
    localparam int c_CMD_W              = 36;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  burst;
        logic [31:0] addr;
    } cmd_t;

    // Wait counter is never narrower than 8 bits, wider when TIMEOUT demands it.
    function automatic int tmo_width(input int timeout);
        return ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ahb_cmd_fifo
// Purpose  : Single-clock command queue with occupancy count; storage is not
//            reset, only pointers and count.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_cmd_fifo
    import ahb_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = c_CMD_W
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ahb_cmd_sequencer
// Purpose  : Queues AHB commands, issues them one at a time to the bus wrapper
//            master, and returns a registered response per command.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_cmd_sequencer
    import ahb_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = c_DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT    = c_DEFAULT_TIMEOUT
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [2:0]                    cmd_burst,
    input  logic [31:0]                   cmd_addr,
    output logic                          op_mode,
    output logic [2:0]                    burst_type,
    output logic [31:0]                   init_addr,
    output logic                          start_transfer,
    input  logic                          bus_done,
    input  logic [31:0]                   bus_rdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_write,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int               c_TW       = tmo_width(TIMEOUT);
    localparam logic [c_TW-1:0]  c_TMO_LAST = c_TW'(TIMEOUT - 1);

    seq_state_t       r_state;
    logic [c_TW-1:0]  r_tmo;
    cmd_t             w_cmd_in;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    assign w_cmd_in  = '{write: cmd_write, burst: cmd_burst, addr: cmd_addr};
    assign cmd_ready = !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty && !rsp_valid;
    assign busy      = (r_state != ST_IDLE) || !w_empty;

    ahb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_CMD_W)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .i_push  (cmd_valid),
        .i_data  (w_cmd_in),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state        <= ST_IDLE;
            r_tmo          <= '0;
            start_transfer <= 1'b0;
            op_mode        <= 1'b0;
            burst_type     <= 3'd0;
            init_addr      <= 32'd0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 32'd0;
            rsp_write      <= 1'b0;
            rsp_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        op_mode        <= w_head.write;
                        burst_type     <= w_head.burst;
                        init_addr      <= w_head.addr;
                        start_transfer <= 1'b1;
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_transfer <= 1'b0;
                    r_tmo          <= '0;
                    r_state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the final allowed cycle beats the timeout.
                    if (bus_done) begin
                        r_state <= ST_CAPTURE;
                    end else if (r_tmo == c_TMO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= 32'd0;
                        rsp_write <= op_mode;
                        rsp_err   <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= op_mode ? 32'd0 : bus_rdata;
                    rsp_write <= op_mode;
                    rsp_err   <= 1'b0;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_cmd_sequencer
// Purpose  : Directed bench with a transaction-level reference model and a
//            per-cycle compare process for ahb_cmd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ahb_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [2:0]  cmd_burst = 3'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic        bus_done = 1'b0, rsp_ready = 1'b1;
    logic [31:0] bus_rdata = 32'd0;
    logic        cmd_ready, op_mode, start_transfer, rsp_valid, rsp_write, rsp_err, busy;
    logic [2:0]  burst_type;
    logic [31:0] init_addr, rsp_data;
    logic [2:0]  fifo_count;

    always #5 HCLK = ~HCLK;

    ahb_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_burst(cmd_burst), .cmd_addr(cmd_addr),
        .op_mode(op_mode), .burst_type(burst_type), .init_addr(init_addr),
        .start_transfer(start_transfer), .bus_done(bus_done), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_write(rsp_write), .rsp_err(rsp_err), .busy(busy), .fifo_count(fifo_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed { bit w; bit [2:0] b; bit [31:0] a; } mcmd_t;
    localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_CAPT = 3, PH_RESP = 4;

    mcmd_t       mq[$];
    mcmd_t       m_cur = '0;
    int          m_ph = PH_IDLE;
    int          m_wait_cycle = 0;
    bit          m_start = 0, m_rv = 0, m_rw = 0, m_re = 0;
    bit [31:0]   m_rd = 0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mq.delete();
            m_cur = '0; m_ph = PH_IDLE; m_wait_cycle = 0;
            m_start = 0; m_rv = 0; m_rw = 0; m_re = 0; m_rd = 0;
        end else begin
            bit acc, pop;
            acc = cmd_valid && (mq.size() < DEPTH);
            pop = 0;
            m_start = 0;
            case (m_ph)
                PH_IDLE: if (mq.size() > 0 && !m_rv) begin
                    m_cur = mq[0]; pop = 1; m_start = 1; m_ph = PH_ISSUE;
                end
                PH_ISSUE: begin m_ph = PH_WAIT; m_wait_cycle = 1; end
                PH_WAIT: begin
                    if (bus_done) m_ph = PH_CAPT;
                    else if (m_wait_cycle == TMO) begin
                        m_rv = 1; m_rd = 0; m_rw = m_cur.w; m_re = 1; m_ph = PH_RESP;
                    end else m_wait_cycle++;
                end
                PH_CAPT: begin
                    m_rv = 1; m_rd = m_cur.w ? 32'd0 : bus_rdata; m_rw = m_cur.w; m_re = 0;
                    m_ph = PH_RESP;
                end
                default: if (rsp_ready) begin m_rv = 0; m_ph = PH_IDLE; end
            endcase
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(mcmd_t'{cmd_write, cmd_burst, cmd_addr});
        end
    end

    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
            chk("fifo_count", 32'(fifo_count), mq.size());
            chk("busy", 32'(busy), 32'(m_ph != PH_IDLE || mq.size() != 0));
            chk("start_transfer", 32'(start_transfer), 32'(m_start));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            if (m_rv || !HRESETn) begin
                chk("rsp_data", rsp_data, m_rd);
                chk("rsp_write", 32'(rsp_write), 32'(m_rw));
                chk("rsp_err", 32'(rsp_err), 32'(m_re));
            end
            if (m_ph == PH_ISSUE || m_ph == PH_WAIT || !HRESETn) begin
                chk("op_mode", 32'(op_mode), 32'(m_cur.w));
                chk("burst_type", 32'(burst_type), 32'(m_cur.b));
                chk("init_addr", init_addr, m_cur.a);
            end
        end
    end

    logic [31:0] starts[$];
    always @(negedge HCLK) if (start_transfer) starts.push_back(init_addr);

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge HCLK); #1;
    endtask

    task automatic push(input logic w, input logic [2:0] b, input logic [31:0] a);
        cmd_valid = 1'b1; cmd_write = w; cmd_burst = b; cmd_addr = a;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!start_transfer && n < 40) begin tick(); n++; end
        chk("start_seen", 32'(start_transfer), 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic pulse_done();
        bus_done = 1'b1; tick(); bus_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        #2 HRESETn = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) tick();
        HRESETn = 1'b1;
        tick();

        // single write, completion 5 cycles after start
        push(1'b1, 3'b000, 32'h0000_0010);
        wait_start(n);
        chk("latency_edges", n, 32'd1);
        chk("wr_op_mode", 32'(op_mode), 32'd1);
        chk("wr_init_addr", init_addr, 32'h0000_0010);
        repeat (5) tick();
        pulse_done();
        wait_rsp(n);
        chk("wr_rsp_write", 32'(rsp_write), 32'd1);
        chk("wr_rsp_data", rsp_data, 32'd0);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // stray completion while idle must do nothing
        pulse_done();
        tick();

        // read with data one cycle after completion
        push(1'b0, 3'b011, 32'h0000_0100);
        wait_start(n);
        chk("rd_burst", 32'(burst_type), 32'd3);
        repeat (2) tick();
        pulse_done();
        bus_rdata = 32'hDEAD_BEEF;
        wait_rsp(n);
        chk("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // timeout with no completion
        push(1'b1, 3'b010, 32'h0000_0200);
        wait_start(n);
        wait_rsp(n);
        chk("tmo_cycles", n, 32'd9);
        chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
        chk("tmo_rsp_data", rsp_data, 32'd0);
        tick();

        // completion on the last allowed wait cycle wins
        push(1'b0, 3'b001, 32'h0000_0300);
        wait_start(n);
        repeat (TMO) tick();
        pulse_done();
        bus_rdata = 32'hCAFE_F00D;
        wait_rsp(n);
        chk("edge_rsp_err", 32'(rsp_err), 32'd0);
        chk("edge_rsp_data", rsp_data, 32'hCAFE_F00D);
        tick();

        // queue full: first entry is popped at issue, so six offers fill it
        base = starts.size();
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_write = i[0]; cmd_burst = i[2:0]; cmd_addr = 32'h1000 + 32'(i * 4);
            tick();
        end
        cmd_valid = 1'b0;
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_fifo_count", 32'(fifo_count), 32'd4);
        n = 0;
        while ((busy || rsp_valid) && n < 200) begin tick(); n++; end
        chk("drain_done", 32'(busy), 32'd0);
        chk("drain_starts", starts.size() - base, 32'd5);
        for (int i = 0; i < 5; i++)
            if (base + i < starts.size())
                chk("drain_order", starts[base + i], 32'h1000 + 32'(i * 4));
        tick();

        // backpressure with two commands queued
        rsp_ready = 1'b0;
        bus_rdata = 32'hA5A5_5A5A;
        push(1'b0, 3'b000, 32'h0000_2000);
        push(1'b1, 3'b001, 32'h0000_2004);
        wait_start(n);
        repeat (2) tick();
        pulse_done();
        wait_rsp(n);
        bus_rdata = 32'h0BAD_F00D;
        bus_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus_done = 1'b0;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'hA5A5_5A5A);
            chk("bp_no_start", 32'(start_transfer), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        wait_start(n);
        chk("bp_restart_latency", n, 32'd1);
        chk("bp_second_addr", init_addr, 32'h0000_2004);
        repeat (2) tick();
        pulse_done();
        wait_rsp(n);
        chk("bp_second_write", 32'(rsp_write), 32'd1);
        tick();

        // reset while waiting with three commands queued
        for (int i = 0; i < 4; i++) push(1'b1, 3'b000, 32'h3000 + 32'(i * 4));
        tick();
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_start", 32'(start_transfer), 32'd0);
        chk("mid_rst_init_addr", init_addr, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
